// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and default widths for the fetch unit
package fetch_pkg;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_unit_inc_register.sv
// incRegister: loadable register with increment; load wins over increment
module incRegister #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             wrEn,
  input  logic             incEn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // load, else increment (wraps naturally), else hold
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) q <= '0;
    else if (wrEn) q <= d;
    else if (incEn) q <= q + WIDTH'(1);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/REQ/WAIT/HOLD instruction fetcher; FETCH_WRAP_ERR_EN adds a sticky PC-wrap error port
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic                  jumpEn,
  input  logic [ADDR_WIDTH-1:0] jumpAddr,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRdEn,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instrValid,
  input  logic                  instrReady,
  output logic                  busy
`ifdef FETCH_WRAP_ERR_EN
  ,
  output logic                  wrapErr
`endif
);
  fetch_state_t state, state_nx;
  logic accept, wrap_stop, pc_wr, pc_inc;
  logic [ADDR_WIDTH-1:0] pc, pc_d;

  incRegister #(.WIDTH(ADDR_WIDTH)) u_pc (
    .clk  (clk),
    .rstN (rstN),
    .wrEn (pc_wr),
    .incEn(pc_inc),
    .d    (pc_d),
    .q    (pc)
  );

  assign accept = state == HOLD && instrReady;

  // state register
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) state <= IDLE;
    else state <= state_nx;

  // next state: HOLD leaves only on acceptance; halt or a pending wrap stop returns to IDLE
  always_comb begin
    state_nx = state == IDLE ? (start ? REQ : IDLE) :
               state == REQ  ? WAIT :
               state == WAIT ? HOLD :
               !instrReady   ? HOLD :
               (halt || wrap_stop) ? IDLE : REQ;
  end

  // outputs and PC control; jump only applies when the accepted instruction continues fetching
  always_comb begin
    memRdEn    = state == REQ;
    instrValid = state == HOLD;
    busy       = state != IDLE;
    memAddr    = pc;
    pc_inc     = state == WAIT;
    pc_wr      = (state == IDLE && start) || (accept && !halt && !wrap_stop && jumpEn);
    pc_d       = state == IDLE ? startAddr : jumpAddr;
  end

  // instruction register captures read data as WAIT ends
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) instr <= '0;
    else if (state == WAIT) instr <= memData;

`ifdef FETCH_WRAP_ERR_EN
  // sticky wrap error; only the wrapping instruction can reach HOLD with it set, so it doubles as the stop request
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) wrapErr <= 1'b0;
    else if (state == IDLE && start) wrapErr <= 1'b0;
    else if (pc_inc && &pc) wrapErr <= 1'b1;
  assign wrap_stop = wrapErr;
`else
  assign wrap_stop = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit sequencing, stalls, jump/halt, wrap and reset
module tb_fetch_unit;
  logic        clk, rstN, start, jumpEn, halt, memRdEn, instrValid, instrReady, busy;
  logic [11:0] startAddr, jumpAddr, memAddr;
  logic [7:0]  memData, instr;
`ifdef FETCH_WRAP_ERR_EN
  logic        wrapErr;
`endif
  int checks = 0;
  int passes = 0;

  fetch_unit dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .startAddr (startAddr),
    .jumpEn    (jumpEn),
    .jumpAddr  (jumpAddr),
    .halt      (halt),
    .memAddr   (memAddr),
    .memRdEn   (memRdEn),
    .memData   (memData),
    .instr     (instr),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .busy      (busy)
`ifdef FETCH_WRAP_ERR_EN
    ,
    .wrapErr   (wrapErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: data = 0xA0 + addr, one cycle after the read strobe
  always @(posedge clk) if (memRdEn) memData <= 8'hA0 + memAddr[7:0];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rstN = 0; start = 0; startAddr = 0; jumpEn = 0; jumpAddr = 0; halt = 0; instrReady = 0; memData = 0;
    tick; tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rden", 32'(memRdEn), 0);
    chk("rst_valid", 32'(instrValid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_addr", 32'(memAddr), 0);
    rstN = 1;
    tick;
    start = 1; startAddr = 12'h010; instrReady = 1;
    tick;
    start = 0;
    chk("req0_rden", 32'(memRdEn), 1);
    chk("req0_addr", 32'(memAddr), 12'h010);
    chk("req0_busy", 32'(busy), 1);
    chk("req0_valid", 32'(instrValid), 0);
    tick;
    chk("wait0_rden", 32'(memRdEn), 0);
    chk("wait0_valid", 32'(instrValid), 0);
    tick;
    chk("hold0_valid", 32'(instrValid), 1);
    chk("hold0_instr", 32'(instr), 8'hB0);
    tick;
    chk("req1_addr", 32'(memAddr), 12'h011);
    chk("req1_rden", 32'(memRdEn), 1);
    tick; tick;
    chk("hold1_instr", 32'(instr), 8'hB1);
    tick;
    chk("req2_addr", 32'(memAddr), 12'h012);
    instrReady = 0;
    tick; tick;
    chk("hold2_instr", 32'(instr), 8'hB2);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("stall_valid", 32'(instrValid), 1);
      chk("stall_instr", 32'(instr), 8'hB2);
      chk("stall_rden", 32'(memRdEn), 0);
    end
    instrReady = 1; jumpEn = 1; jumpAddr = 12'h200;
    tick;
    jumpEn = 0;
    chk("jump_addr", 32'(memAddr), 12'h200);
    tick;
    jumpEn = 1; jumpAddr = 12'h300;
    tick;
    jumpEn = 0;
    chk("hold_jmp_instr", 32'(instr), 8'hA0);
    tick;
    chk("wait_jump_ignored", 32'(memAddr), 12'h201);
    start = 1; startAddr = 12'h555;
    tick;
    start = 0;
    tick;
    chk("start_ignored_instr", 32'(instr), 8'hA1);
    halt = 1; jumpEn = 1; jumpAddr = 12'h300;
    tick;
    halt = 0; jumpEn = 0;
    chk("halt_busy", 32'(busy), 0);
    chk("halt_valid", 32'(instrValid), 0);
    chk("halt_pc", 32'(memAddr), 12'h202);
    tick;
    chk("idle_stays", 32'(busy), 0);
    start = 1; startAddr = 12'hFFF;
    tick;
    start = 0;
    chk("wrap_req_addr", 32'(memAddr), 12'hFFF);
    tick; tick;
    chk("wrap_instr", 32'(instr), 8'h9F);
`ifdef FETCH_WRAP_ERR_EN
    chk("wrap_err_set", 32'(wrapErr), 1);
    tick;
    chk("wrap_idle", 32'(busy), 0);
    chk("wrap_err_sticky", 32'(wrapErr), 1);
    start = 1; startAddr = 12'h000;
    tick;
    start = 0;
    chk("wrap_err_clr", 32'(wrapErr), 0);
`else
    tick;
`endif
    chk("wrap_next_addr", 32'(memAddr), 12'h000);
    chk("wrap_next_rden", 32'(memRdEn), 1);
    tick;
    rstN = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rden", 32'(memRdEn), 0);
    chk("arst_valid", 32'(instrValid), 0);
    chk("arst_instr", 32'(instr), 0);
    chk("arst_addr", 32'(memAddr), 0);
    tick;
    rstN = 1;
    tick;
    start = 1; startAddr = 12'h055;
    tick;
    start = 0;
    chk("restart_addr", 32'(memAddr), 12'h055);
    tick; tick;
    chk("restart_valid", 32'(instrValid), 1);
    chk("restart_instr", 32'(instr), 8'hF5);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
